// File: rtl/rv32_pkg.sv
// rv32_pkg
//   Shared definitions for the RV32M multiply/divide sequencing logic.
//   - XLEN           : default datapath width
//   - F3_*           : M-extension funct3 encodings (bit2 set -> divide class)
//   - md_state_t     : sequencer state encoding
package rv32_pkg;

   localparam int XLEN = 32;

   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   localparam logic [2:0] F3_DIV    = 3'b100;
   localparam logic [2:0] F3_DIVU   = 3'b101;
   localparam logic [2:0] F3_REM    = 3'b110;
   localparam logic [2:0] F3_REMU   = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } md_state_t;

endpackage

// File: rtl/md_special_case.sv
// md_special_case
//   Combinational detector for divide operations whose RISC-V result is fixed
//   by rule and therefore never needs the iterative unit.
//   Ports:
//     op         in  3  funct3 of the M instruction
//     a, b       in  W  operands (rs1, rs2)
//     isFast     out 1  result is available without launching the unit
//     fastResult out W  that result (0 when isFast is low)
module md_special_case #(
   parameter int W = 32
) (
   input  logic [2:0]   op,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         isFast,
   output logic [W-1:0] fastResult
);
   import rv32_pkg::*;

   localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

   logic div_zero;
   logic sgn_ovf;

   always_comb begin
      div_zero   = (b == '0);
      // op[0]==0 within the divide class selects the signed forms (DIV/REM)
      sgn_ovf    = !op[0] && (a == MOST_NEG) && (b == '1);
      isFast     = 1'b0;
      fastResult = '0;
      if (op[2]) begin
         if (div_zero) begin
            isFast     = 1'b1;
            // REM/REMU return the dividend, DIV/DIVU return all ones
            fastResult = (op == F3_REM || op == F3_REMU) ? a : '1;
         end else if (sgn_ovf) begin
            isFast     = 1'b1;
            fastResult = (op == F3_REM) ? '0 : MOST_NEG;
         end
      end
   end

endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
//   Launches the iterative RV32M multiply/divide unit, waits out its fixed
//   latency, captures the result and stalls the front of the pipeline while
//   an M op occupies EX. Divide-by-zero and signed overflow are resolved
//   locally without touching the unit.
//   Ports:
//     clk, rst_n       clock, async active-low reset
//     mdValidEx        EX holds a valid M instruction
//     mdOpEx           its funct3
//     rs1Ex, rs2Ex     forwarded operands
//     flushEx          kill the instruction in EX
//     unitStart        1-cycle launch pulse to the unit
//     unitAbort        1-cycle discard pulse for an in-flight op
//     unitOp/A/B       operands latched at launch
//     unitResult       unit output, sampled when the counter expires
//     mdStall          hold PC, IF/ID and ID/EX
//     mdResultValid    mdResult is valid this cycle
//     mdResult         result of the completed M instruction
module muldiv_sequencer #(
   parameter int XLEN       = 32,
   parameter int MUL_CYCLES = 4,
   parameter int DIV_CYCLES = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            mdValidEx,
   input  logic [2:0]      mdOpEx,
   input  logic [XLEN-1:0] rs1Ex,
   input  logic [XLEN-1:0] rs2Ex,
   input  logic            flushEx,
   output logic            unitStart,
   output logic            unitAbort,
   output logic [2:0]      unitOp,
   output logic [XLEN-1:0] unitA,
   output logic [XLEN-1:0] unitB,
   input  logic [XLEN-1:0] unitResult,
   output logic            mdStall,
   output logic            mdResultValid,
   output logic [XLEN-1:0] mdResult
);
   import rv32_pkg::*;

   localparam int CW = $clog2(DIV_CYCLES + 1);
   localparam logic [CW-1:0] MUL_LAT_M1 = CW'(MUL_CYCLES - 1);
   localparam logic [CW-1:0] DIV_LAT_M1 = CW'(DIV_CYCLES - 1);

   md_state_t       state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2:0]      op_q, op_d;
   logic [XLEN-1:0] a_q, a_d;
   logic [XLEN-1:0] b_q, b_d;
   logic [XLEN-1:0] res_q, res_d;
   logic            start_q, start_d;

   logic            is_fast;
   logic [XLEN-1:0] fast_result;

   md_special_case #(.W(XLEN)) u_special (
      .op         (mdOpEx),
      .a          (rs1Ex),
      .b          (rs2Ex),
      .isFast     (is_fast),
      .fastResult (fast_result)
   );

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      op_d          = op_q;
      a_d           = a_q;
      b_d           = b_q;
      res_d         = res_q;
      start_d       = 1'b0;
      mdStall       = 1'b0;
      mdResultValid = 1'b0;
      unitAbort     = 1'b0;
      case (state_q)
         IDLE: begin
            if (mdValidEx && !flushEx) begin
               mdStall = 1'b1;
               if (is_fast) begin
                  res_d   = fast_result;
                  state_d = DONE;
               end else begin
                  op_d    = mdOpEx;
                  a_d     = rs1Ex;
                  b_d     = rs2Ex;
                  start_d = 1'b1;
                  cnt_d   = mdOpEx[2] ? DIV_LAT_M1 : MUL_LAT_M1;
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            // flush wins over counter expiry; the unit is told to drop the op
            if (flushEx) begin
               unitAbort = 1'b1;
               state_d   = IDLE;
            end else begin
               mdStall = 1'b1;
               if (cnt_q == '0) begin
                  res_d   = unitResult;
                  state_d = DONE;
               end else begin
                  cnt_d = cnt_q - CW'(1);
               end
            end
         end
         DONE: begin
            // no stall here: the instruction leaves EX at this edge
            mdResultValid = !flushEx;
            state_d       = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         start_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         start_q <= start_d;
      end
   end

   assign unitStart = start_q;
   assign unitOp    = op_q;
   assign unitA     = a_q;
   assign unitB     = b_q;
   assign mdResult  = res_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
module tb_muldiv_sequencer;

   localparam int MUL_LAT = 4;
   localparam int DIV_LAT = 32;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        mdValidEx;
   logic [2:0]  mdOpEx;
   logic [31:0] rs1Ex, rs2Ex;
   logic        flushEx;
   logic        unitStart, unitAbort;
   logic [2:0]  unitOp;
   logic [31:0] unitA, unitB, unitResult;
   logic        mdStall, mdResultValid;
   logic [31:0] mdResult;

   muldiv_sequencer #(.XLEN(32), .MUL_CYCLES(MUL_LAT), .DIV_CYCLES(DIV_LAT)) dut (
      .clk(clk), .rst_n(rst_n), .mdValidEx(mdValidEx), .mdOpEx(mdOpEx),
      .rs1Ex(rs1Ex), .rs2Ex(rs2Ex), .flushEx(flushEx),
      .unitStart(unitStart), .unitAbort(unitAbort), .unitOp(unitOp),
      .unitA(unitA), .unitB(unitB), .unitResult(unitResult),
      .mdStall(mdStall), .mdResultValid(mdResultValid), .mdResult(mdResult)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // expectations for the current cycle, produced by the driver from the op timeline
   logic        chk_en = 1'b0;
   logic        exp_stall, exp_valid, exp_start, exp_abort;
   logic [31:0] exp_res, exp_a, exp_b;
   logic [2:0]  exp_op;

   logic [31:0] last_res = '0, prev_res = '0;
   int          n_abort = 0, n_valid = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
      end
   endtask

   // RISC-V M-extension semantics in plain arithmetic
   function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] sa, sb, ua, ub, p;
      logic signed [31:0] as, bs;
      sa = {{32{a[31]}}, a}; sb = {{32{b[31]}}, b};
      ua = {32'b0, a};       ub = {32'b0, b};
      as = a; bs = b;
      case (op)
         3'b000: begin p = ua * ub; return p[31:0]; end
         3'b001: begin p = sa * sb; return p[63:32]; end
         3'b010: begin p = sa * ub; return p[63:32]; end
         3'b011: begin p = ua * ub; return p[63:32]; end
         3'b100: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            return as / bs;
         end
         3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'b110: begin
            if (b == 0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
            return as % bs;
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic bit ref_fast(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      if (!op[2]) return 1'b0;
      if (b == 0) return 1'b1;
      return (op == 3'b100 || op == 3'b110) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
   endfunction

   // single compare process
   always @(negedge clk) begin
      if (chk_en) begin
         check("mdStall", {31'b0, mdStall}, {31'b0, exp_stall});
         check("mdResultValid", {31'b0, mdResultValid}, {31'b0, exp_valid});
         check("unitStart", {31'b0, unitStart}, {31'b0, exp_start});
         check("unitAbort", {31'b0, unitAbort}, {31'b0, exp_abort});
         if (exp_valid) check("mdResult", mdResult, exp_res);
         if (exp_start) begin
            check("unitOp", {29'b0, unitOp}, {29'b0, exp_op});
            check("unitA", unitA, exp_a);
            check("unitB", unitB, exp_b);
         end
      end
      if (mdResultValid) begin
         prev_res = last_res;
         last_res = mdResult;
         n_valid++;
      end
      if (unitAbort) n_abort++;
   end

   task automatic set_idle_exp();
      exp_stall = 0; exp_valid = 0; exp_start = 0; exp_abort = 0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         mdValidEx = 0; mdOpEx = 3'($urandom); rs1Ex = $urandom; rs2Ex = $urandom;
         flushEx = ($urandom_range(0, 3) == 0); unitResult = $urandom;
         set_idle_exp();
      end
   endtask

   // One M instruction in EX. Age = cycles since it entered EX.
   // Through the unit it occupies EX for LAT+2 cycles, fast path for 2.
   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int flush_at, input int rst_at);
      bit fast; logic [31:0] r; int lat, occ;
      fast = ref_fast(op, a, b);
      r    = ref_result(op, a, b);
      lat  = fast ? 0 : (op[2] ? DIV_LAT : MUL_LAT);
      occ  = lat + 2;
      for (int age = 0; age < occ; age++) begin
         @(posedge clk); #1;
         mdValidEx = 1; mdOpEx = op;
         rs1Ex = (age == 0) ? a : $urandom;   // forwarding noise after launch
         rs2Ex = (age == 0) ? b : $urandom;
         flushEx = (age == flush_at);
         unitResult = (!fast && age == lat) ? r : $urandom;
         exp_stall = !flushEx && age < occ - 1;
         exp_valid = !flushEx && age == occ - 1;
         exp_start = !fast && age == 1;
         exp_abort = flushEx && !fast && age >= 1 && age <= lat;
         exp_res = r; exp_op = op; exp_a = a; exp_b = b;
         if (age == rst_at) begin
            chk_en = 0;
            #2 rst_n = 0; mdValidEx = 0; flushEx = 0;
            #1;
            check("rst_unitStart", {31'b0, unitStart}, 32'd0);
            check("rst_unitAbort", {31'b0, unitAbort}, 32'd0);
            check("rst_mdStall", {31'b0, mdStall}, 32'd0);
            check("rst_mdResultValid", {31'b0, mdResultValid}, 32'd0);
            check("rst_unitOp", {29'b0, unitOp}, 32'd0);
            check("rst_unitA", unitA, 32'd0);
            check("rst_unitB", unitB, 32'd0);
            check("rst_mdResult", mdResult, 32'd0);
            @(posedge clk); #1;
            rst_n = 1; set_idle_exp(); chk_en = 1;
            return;
         end
         if (flushEx) break;
      end
   endtask

   int na, nv;

   initial begin
      rst_n = 0; mdValidEx = 0; mdOpEx = 0; rs1Ex = 0; rs2Ex = 0; flushEx = 0; unitResult = 0;
      set_idle_exp();
      #12;
      check("reset_stall", {31'b0, mdStall}, 32'd0);
      check("reset_valid", {31'b0, mdResultValid}, 32'd0);
      check("reset_start", {31'b0, unitStart}, 32'd0);
      check("reset_abort", {31'b0, unitAbort}, 32'd0);
      check("reset_result", mdResult, 32'd0);
      check("reset_unitA", unitA, 32'd0);
      @(posedge clk); #1 rst_n = 1; chk_en = 1;
      idle(2);

      // pin the model itself
      check("model_mulh", ref_result(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'h0);
      check("model_mulhu", ref_result(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFE);
      check("model_div_neg", ref_result(3'b100, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
      check("model_rem_neg", ref_result(3'b110, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);

      // 1. MUL 7*6
      run_op(3'b000, 32'd7, 32'd6, -1, -1);
      idle(1);
      check("t1_mul_42", last_res, 32'd42);
      // 2. divide by zero
      run_op(3'b101, 32'd100, 32'd0, -1, -1);
      idle(1);
      check("t2_divu_zero", last_res, 32'hFFFF_FFFF);
      run_op(3'b111, 32'd100, 32'd0, -1, -1);
      idle(1);
      check("t2_remu_zero", last_res, 32'd100);
      // 3. signed overflow
      run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1);
      idle(1);
      check("t3_div_ovf", last_res, 32'h8000_0000);
      run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1);
      idle(1);
      check("t3_rem_ovf", last_res, 32'h0);
      // 4. flush in RUN cycle 10
      na = n_abort; nv = n_valid;
      run_op(3'b100, 32'd1000, 32'd3, 10, -1);
      idle(3);
      check("t4_abort_once", n_abort - na, 32'd1);
      check("t4_no_valid", n_valid - nv, 32'd0);
      // 5. back-to-back MUL
      run_op(3'b000, 32'd3, 32'd5, -1, -1);
      run_op(3'b000, 32'd9, 32'd9, -1, -1);
      idle(1);
      check("t5_first", prev_res, 32'd15);
      check("t5_second", last_res, 32'd81);
      // 6. reset mid-RUN, then a normal op
      run_op(3'b100, 32'd1000, 32'd7, -1, 5);
      idle(1);
      run_op(3'b101, 32'd1000, 32'd7, -1, -1);
      idle(1);
      check("t6_after_reset", last_res, 32'd142);

      // randomized traffic
      for (int n = 0; n < 60; n++) begin
         logic [2:0] op; logic [31:0] a, b; int sel, fa;
         op = 3'($urandom_range(0, 7)); a = $urandom; b = $urandom;
         sel = $urandom_range(0, 9);
         if (sel == 0) b = 0;
         else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
         else if (sel == 2) begin a = a % 1000; b = b % 20; end
         fa = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 35) : -1;
         run_op(op, a, b, fa, -1);
         idle($urandom_range(0, 2));
      end

      idle(2);
      chk_en = 0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
